seg_scan_controller: RTL and testbench

Time-multiplexed scan controller for the segment-display datapath. It sequences the 32-bit display value held by the memory-mapped slave register across NUM_DIGITS common-select digits. The value is shadowed, so a bus write takes effect only at a frame boundary and never tears a frame. It inserts an all-off blanking interval at every digit change to prevent ghosting, and can optionally blank leading zeros.

---
 rtl/seg_disp_pkg.sv | 26 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg_scan_controller.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the segment-display scan datapath.
// Segment vectors are ordered {g,f,e,d,c,b,a}, so bit 0 is segment a.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  localparam int SEG_WIDTH = 7;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // High-true patterns for hex digits 0..F
  localparam logic [SEG_WIDTH-1:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decode (high-true, {g,f,e,d,c,b,a}).
module hex_to_seg7
  import seg_disp_pkg::*;
(
  input  logic [3:0]           hex,
  output logic [SEG_WIDTH-1:0] seg
);

  assign seg = SEG7_TABLE[hex];

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed digit scanner with frame-aligned shadow data, per-slot blanking
// interval, optional leading-zero suppression and selectable output polarity.
module seg_scan_controller
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    lz_blank,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [SEG_WIDTH-1:0]    seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic          POL        = (ACTIVE_LOW != 0);

  scan_state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [IW-1:0] idx_reg, idx_next;

  logic [DW-1:0]         active_data_reg, pend_data_reg;
  logic [NUM_DIGITS-1:0] active_dp_reg, pend_dp_reg;
  logic                  pend_reg;

  logic [SEG_WIDTH-1:0]  seg_reg, seg_next;
  logic                  dp_reg, dp_next;
  logic [NUM_DIGITS-1:0] sel_reg, sel_next;
  logic                  frame_done_reg, frame_done_next;

  logic                  boundary;
  logic                  drive_on;
  logic                  lz_hide;
  logic [3:0]            cur_nibble;
  logic [SEG_WIDTH-1:0]  seg_dec;
  logic [NUM_DIGITS:0]   zero_from;
  logic [NUM_DIGITS-1:0] sel_onehot;

  // Slot counter runs continuously 0..SLOT_CYCLES-1; the first BLANK_CYCLES are the off interval
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    if (!enable) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          idx_next   = '0;
        end
        ST_BLANK: begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == BLANK_LAST) begin
            state_next = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt_reg == SLOT_LAST) begin
            cnt_next   = '0;
            state_next = ST_BLANK;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  assign boundary = (state_next == ST_BLANK) && (state_reg != ST_BLANK) && (idx_next == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Active data only changes on a frame boundary, so a frame is never torn
  always_ff @(posedge clk) begin
    if (!reset) begin
      active_data_reg <= '0;
      active_dp_reg   <= '0;
      pend_data_reg   <= '0;
      pend_dp_reg     <= '0;
      pend_reg        <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        active_data_reg <= data_in;
        active_dp_reg   <= dp_in;
      end else if (pend_reg) begin
        active_data_reg <= pend_data_reg;
        active_dp_reg   <= pend_dp_reg;
      end
      pend_reg <= 1'b0;
    end else if (load) begin
      pend_data_reg <= data_in;
      pend_dp_reg   <= dp_in;
      pend_reg      <= 1'b1;
    end
  end

  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero
  assign zero_from[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign zero_from[gi]  = (active_data_reg[4*gi +: 4] == 4'h0) && zero_from[gi+1];
      assign sel_onehot[gi] = (idx_reg == IW'(gi));
    end
  endgenerate

  assign cur_nibble = active_data_reg[{idx_reg, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (cur_nibble),
    .seg (seg_dec)
  );

  assign drive_on = enable && (state_reg == ST_DRIVE);
  assign lz_hide  = lz_blank && (idx_reg != '0) && zero_from[idx_reg];

  always_comb begin
    seg_next        = (drive_on && !lz_hide) ? seg_dec : '0;
    dp_next         = drive_on && active_dp_reg[idx_reg];
    sel_next        = drive_on ? sel_onehot : '0;
    frame_done_next = enable && (state_reg == ST_DRIVE) && (cnt_reg == SLOT_LAST)
                      && (idx_reg == IDX_LAST);
  end

  // Polarity is folded in at the output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_reg        <= {SEG_WIDTH{POL}};
      dp_reg         <= POL;
      sel_reg        <= {NUM_DIGITS{POL}};
      frame_done_reg <= 1'b0;
    end else begin
      seg_reg        <= seg_next ^ {SEG_WIDTH{POL}};
      dp_reg         <= dp_next ^ POL;
      sel_reg        <= sel_next ^ {NUM_DIGITS{POL}};
      frame_done_reg <= frame_done_next;
    end
  end

  assign seg_out    = seg_reg;
  assign dp_out     = dp_reg;
  assign digit_sel  = sel_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller: fixed vector table, directed frame
// sequences and randomized traffic against a position-based reference model.
module tb_seg_scan_controller;

  localparam int N     = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          lz_blank = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   data_in = '0;
  logic [3:0]    dp_in = '0;
  logic [6:0]    seg_out;
  logic          dp_out;
  logic [3:0]    digit_sel;
  logic          frame_done;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .NUM_DIGITS   (N),
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK),
    .ACTIVE_LOW   (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: scan position counts cycles since leaving idle (-1 = idle)
  int          m_pos = -1;
  logic [15:0] m_act = '0, m_pend = '0;
  logic [3:0]  m_act_dp = '0, m_pend_dp = '0;
  logic        m_flag = 1'b0;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [3:0]  e_sel;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst, en, lz, ld;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        odp;
    logic [3:0]  sel;
    logic        fd;
  } vec_t;

  vec_t vt [16];

  task automatic model_step(input logic rst, input logic en, input logic lz, input logic ld,
                            input logic [15:0] d, input logic [3:0] p);
    int  dig, off;
    logic bnd;
    e_seg = '0; e_dp = 1'b0; e_sel = '0; e_fd = 1'b0;
    if (!rst) begin
      m_pos = -1; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_flag = 1'b0;
    end else begin
      if (en && m_pos >= 0) begin
        dig = (m_pos / SLOT) % N;
        off = m_pos % SLOT;
        if (off >= BLANK) begin
          e_sel = 4'(1 << dig);
          e_dp  = m_act_dp[dig];
          if (lz && dig > 0 && (m_act >> (4 * dig)) == 16'h0) e_seg = '0;
          else e_seg = seg_tab[m_act[4*dig +: 4]];
        end
        e_fd = ((m_pos + 1) % FRAME) == 0;
      end
      bnd = en && (m_pos < 0 || ((m_pos + 1) % FRAME) == 0);
      if (bnd) begin
        if (ld) begin
          m_act = d; m_act_dp = p;
        end else if (m_flag) begin
          m_act = m_pend; m_act_dp = m_pend_dp;
        end
        m_flag = 1'b0;
      end else if (ld) begin
        m_pend = d; m_pend_dp = p; m_flag = 1'b1;
      end
      m_pos = en ? m_pos + 1 : -1;
    end
  endtask

  task automatic apply(input logic rst, input logic en, input logic lz, input logic ld,
                       input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    reset = rst; enable = en; lz_blank = lz; load = ld; data_in = d; dp_in = p;
    model_step(rst, en, lz, ld, d, p);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] s, input logic dpv,
                       input logic [3:0] sl, input logic fd);
    n_vec++;
    if (seg_out !== s || dp_out !== dpv || digit_sel !== sl || frame_done !== fd) begin
      n_bad++;
      $display("FAIL %s t=%0t: got seg=%h dp=%b sel=%b fd=%b, want seg=%h dp=%b sel=%b fd=%b",
               name, $time, seg_out, dp_out, digit_sel, frame_done, s, dpv, sl, fd);
    end
  endtask

  task automatic run_model(input string name, input int cycles, input logic lz);
    for (int i = 0; i < cycles; i++) begin
      apply(1'b1, 1'b1, lz, 1'b0, 16'h0, 4'h0);
      check(name, e_seg, e_dp, e_sel, e_fd);
    end
  endtask

  // Advance (bounded) until the model sits at the given frame phase
  task automatic seek_phase(input int phase, input logic lz);
    for (int i = 0; i < 2 * FRAME && (m_pos % FRAME) != phase; i++) begin
      apply(1'b1, 1'b1, lz, 1'b0, 16'h0, 4'h0);
      check("seek", e_seg, e_dp, e_sel, e_fd);
    end
  endtask

  initial begin
    // rst en lz ld data dp | seg dp sel fd
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h00, 1'b0, 4'b0000, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h00, 1'b0, 4'b0000, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h00, 1'b0, 4'b0000, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 4'h1, 7'h00, 1'b0, 4'b0000, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h00, 1'b0, 4'b0000, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h00, 1'b0, 4'b0000, 1'b0};
    for (int i = 6; i < 12; i++)
      vt[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h6D, 1'b1, 4'b0001, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h00, 1'b0, 4'b0000, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h00, 1'b0, 4'b0000, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h3F, 1'b0, 4'b0010, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 7'h3F, 1'b0, 4'b0010, 1'b0};

    for (int i = 0; i < 16; i++) begin
      apply(vt[i].rst, vt[i].en, vt[i].lz, vt[i].ld, vt[i].data, vt[i].dp);
      check($sformatf("table[%0d]", i), vt[i].seg, vt[i].odp, vt[i].sel, vt[i].fd);
    end
    run_model("scan", 2 * FRAME, 1'b0);

    // Shadowed load of A1F8 takes effect at the next frame
    apply(1'b1, 1'b1, 1'b0, 1'b1, 16'hA1F8, 4'b0100);
    check("load_a1f8", e_seg, e_dp, e_sel, e_fd);
    run_model("frame_a1f8", 2 * FRAME, 1'b0);

    // Two loads in one frame: last write wins, first never shown
    seek_phase(10, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 4'h0);
    check("load_1234", e_seg, e_dp, e_sel, e_fd);
    run_model("mid", 5, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h5678, 4'h0);
    check("load_5678", e_seg, e_dp, e_sel, e_fd);
    run_model("frame_5678", 2 * FRAME, 1'b0);

    // Load exactly on the boundary cycle goes straight to the new frame
    seek_phase(FRAME - 1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h0F0F, 4'h0);
    check("load_bnd", e_seg, e_dp, e_sel, e_fd);
    run_model("frame_0f0f", FRAME + 4, 1'b0);

    // Leading-zero blanking
    apply(1'b1, 1'b1, 1'b1, 1'b1, 16'h0030, 4'h0);
    check("load_0030", e_seg, e_dp, e_sel, e_fd);
    run_model("lz_0030", 2 * FRAME, 1'b1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 4'h0);
    check("load_0000", e_seg, e_dp, e_sel, e_fd);
    run_model("lz_0000", 2 * FRAME, 1'b1);

    // Enable dropped during digit2 drive, then reset during drive
    apply(1'b1, 1'b1, 1'b0, 1'b1, 16'h4321, 4'b1010);
    check("load_4321", e_seg, e_dp, e_sel, e_fd);
    run_model("pre_en", FRAME, 1'b0);
    seek_phase(2 * SLOT + 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
      check("en_off", 7'h00, 1'b0, 4'b0000, 1'b0);
    end
    run_model("resume_en", FRAME + 4, 1'b0);
    seek_phase(SLOT + 5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
      check("rst_off", 7'h00, 1'b0, 4'b0000, 1'b0);
    end
    run_model("resume_rst", FRAME + 4, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_en, r_lz, r_ld;
      logic [15:0] r_d;
      r_rst = ($urandom_range(0, 299) != 0);
      r_en  = ($urandom_range(0, 39) != 0);
      r_lz  = ($urandom_range(0, 3) != 0);
      r_ld  = ($urandom_range(0, 11) == 0);
      for (int k = 0; k < 4; k++)
        r_d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      apply(r_rst, r_en, r_lz, r_ld, r_d, 4'($urandom_range(0, 15)));
      check("random", e_seg, e_dp, e_sel, e_fd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
